// File: rtl/dl_demux16_reg.sv
// dl_demux16_reg: registered 1-to-16 valid/ready demux, one-word register per channel.
// Optional per-channel output transfer counters are enabled with `define DL_DEMUX16_CNT_EN.
module dl_demux16_reg #(
    parameter int NUM_BITS = 32,
    parameter int CNT_BITS = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NUM_BITS-1:0]       in_data,
    input  logic [3:0]                in_sel,
    output logic [15:0]               out_valid,
    input  logic [15:0]               out_ready,
    output logic [15:0][NUM_BITS-1:0] out_data
`ifdef DL_DEMUX16_CNT_EN
    ,
    output logic [15:0][CNT_BITS-1:0] xfer_cnt
`endif
);
    logic [15:0]               valid_q, valid_d, ld, drain;
    logic [15:0][NUM_BITS-1:0] data_q, data_d;

    assign in_ready  = !valid_q[in_sel] || out_ready[in_sel];
    assign out_valid = valid_q;
    assign out_data  = data_q;

    // Load wins over drain on the same channel; untouched channels drain freely.
    always_comb begin
        ld      = (in_valid && in_ready) ? (16'd1 << in_sel) : 16'd0;
        drain   = valid_q & out_ready;
        valid_d = (valid_q & ~drain) | ld;
        for (int i = 0; i < 16; i++) data_d[i] = ld[i] ? in_data : data_q[i];
    end

    // Channel registers; reset discards every held word and any same-cycle accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

`ifdef DL_DEMUX16_CNT_EN
    logic [15:0][CNT_BITS-1:0] cnt_q, cnt_d;

    assign xfer_cnt = cnt_q;

    // Count output handshakes per channel, wrapping freely.
    always_comb begin
        for (int i = 0; i < 16; i++) cnt_d[i] = cnt_q[i] + CNT_BITS'(drain[i]);
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
`else
    if (CNT_BITS < 1) begin : g_cnt_width_unused
    end
`endif
endmodule
